// File: rtl/edge_event_arbiter_pkg.sv
// Shared constants and FSM encoding for the edge event arbiter.
package edge_event_arbiter_pkg;

    localparam int WARMUP_CYCLES = 3;
    localparam int SYNC_STAGES   = 2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/edge_sync_detect.sv
// Per-channel synchroniser with rising/falling edge pulse detection.
module edge_sync_detect
    import edge_event_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic in_s,
    output logic rise_p,
    output logic fall_p
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s3;
    logic                   s2;

    assign s2 = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s3     <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_s};
            s3     <= s2;
        end
    end

    assign rise_p = s2 & ~s3;
    assign fall_p = ~s2 & s3;

endmodule

// File: rtl/edge_event_arbiter.sv
// Edge-event collector: pending/overflow tracking, round-robin pick, one event port.
module edge_event_arbiter
    import edge_event_arbiter_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] in_s,
    input  logic [N_CH-1:0] ch_en,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [CH_W-1:0] evt_ch,
    output logic            evt_rise,
    output logic            evt_fall,
    output logic [N_CH-1:0] ovf,
    input  logic [N_CH-1:0] ovf_clr
);

    logic [N_CH-1:0] rise_p;
    logic [N_CH-1:0] fall_p;
    logic [N_CH-1:0] rise_v;
    logic [N_CH-1:0] fall_v;
    logic [N_CH-1:0] rp;
    logic [N_CH-1:0] fp;
    logic [N_CH-1:0] pend;
    logic [N_CH-1:0] clr;
    logic [1:0]      wu;
    logic            armed;
    logic            load;
    logic            found;
    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] win;
    int              idx;
    state_t          state;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_sync_detect u_sync (
            .clk    (clk),
            .rst_n  (rst_n),
            .in_s   (in_s[i]),
            .rise_p (rise_p[i]),
            .fall_p (fall_p[i])
        );
    end

    // Masks the bogus edge seen when an input is already high at reset release.
    assign armed = (wu == 2'(WARMUP_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wu <= '0;
        end else if (!armed) begin
            wu <= wu + 2'd1;
        end
    end

    assign rise_v = rise_p & ch_en & {N_CH{armed}};
    assign fall_v = fall_p & ch_en & {N_CH{armed}};
    assign pend   = rp | fp;
    assign load   = (|pend) && ((state == ST_EMPTY) || evt_ready);

    always_comb begin
        win   = ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(ptr) + k) % N_CH;
            if (!found && pend[idx[CH_W-1:0]]) begin
                found = 1'b1;
                win   = CH_W'(idx);
            end
        end
    end

    assign clr = load ? (N_CH'(1) << win) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp  <= '0;
            fp  <= '0;
            ovf <= '0;
        end else begin
            rp  <= ch_en & (rise_v | (rp & ~clr));
            fp  <= ch_en & (fall_v | (fp & ~clr));
            ovf <= (ovf & ~ovf_clr)
                 | (rise_v & rp & ~clr)
                 | (fall_v & fp & ~clr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_rise  <= 1'b0;
            evt_fall  <= 1'b0;
            ptr       <= CH_W'(N_CH - 1);
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (load) begin
                        state     <= ST_FULL;
                        evt_valid <= 1'b1;
                        evt_ch    <= win;
                        evt_rise  <= rp[win];
                        evt_fall  <= fp[win];
                        ptr       <= win;
                    end
                end
                ST_FULL: begin
                    if (load) begin
                        evt_ch   <= win;
                        evt_rise <= rp[win];
                        evt_fall <= fp[win];
                        ptr      <= win;
                    end else if (evt_ready) begin
                        state     <= ST_EMPTY;
                        evt_valid <= 1'b0;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: event-level model plus directed scenarios.
module tb_edge_event_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_s;
    logic [3:0] ch_en;
    logic [3:0] ovf;
    logic [3:0] ovf_clr;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_ch;
    logic       evt_rise;
    logic       evt_fall;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #10 clk = ~clk;

    edge_event_arbiter #(.N_CH(4), .CH_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_s      (in_s),
        .ch_en     (ch_en),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_rise  (evt_rise),
        .evt_fall  (evt_fall),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: in_s history per edge, pending sets, round-robin, one output slot.
    logic [3:0] h0, h1, h2;
    logic [3:0] m_rp, m_fp, m_ovf;
    logic [3:0] s2, s3, rv, fv, pnd, clr;
    int         m_nedge, m_ptr, m_ch, win, mc;
    bit         m_v, m_r, m_f, load;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h0 = 0; h1 = 0; h2 = 0;
            m_rp = 0; m_fp = 0; m_ovf = 0;
            m_nedge = 0; m_ptr = 3; m_ch = 0;
            m_v = 0; m_r = 0; m_f = 0;
        end else begin
            s2 = h1;
            s3 = h2;
            rv = (m_nedge < 3) ? 4'b0 : (s2 & ~s3 & ch_en);
            fv = (m_nedge < 3) ? 4'b0 : (~s2 & s3 & ch_en);
            pnd = m_rp | m_fp;
            win = -1;
            for (int k = 1; k <= 4; k++) begin
                mc = (m_ptr + k) % 4;
                if (win < 0 && pnd[mc]) win = mc;
            end
            load = (pnd != 0) && (!m_v || evt_ready);
            clr = 0;
            if (load) begin
                clr[win] = 1'b1;
                m_v = 1; m_ch = win; m_r = m_rp[win]; m_f = m_fp[win]; m_ptr = win;
            end else if (m_v && evt_ready) begin
                m_v = 0;
            end
            for (int i = 0; i < 4; i++) begin
                m_ovf[i] = m_ovf[i] & ~ovf_clr[i];
                if ((rv[i] && m_rp[i] && !clr[i]) || (fv[i] && m_fp[i] && !clr[i]))
                    m_ovf[i] = 1'b1;
                if (!ch_en[i]) begin
                    m_rp[i] = 0; m_fp[i] = 0;
                end else begin
                    m_rp[i] = rv[i] | (m_rp[i] & ~clr[i]);
                    m_fp[i] = fv[i] | (m_fp[i] & ~clr[i]);
                end
            end
            h2 = h1; h1 = h0; h0 = in_s;
            if (m_nedge < 3) m_nedge++;
        end
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        chk("m_valid", evt_valid, m_v);
        if (m_v) begin
            chk("m_ch", evt_ch, m_ch);
            chk("m_rise", evt_rise, m_r);
            chk("m_fall", evt_fall, m_f);
        end
        chk("m_ovf", ovf, m_ovf);
    end

    int         log_ch[$];
    logic [1:0] log_rf[$];
    int         log_t[$];

    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            log_ch.push_back(evt_ch);
            log_rf.push_back({evt_rise, evt_fall});
            log_t.push_back(cyc);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_log();
        log_ch.delete();
        log_rf.delete();
        log_t.delete();
    endtask

    task automatic wait_log(input string nm, input int n, input int budget);
        int k = 0;
        while (log_ch.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk(nm, log_ch.size(), n);
    endtask

    task automatic chk3(input string nm, input logic [1:0] rf);
        chk({nm, "_ch0"}, log_ch[0], 0);
        chk({nm, "_ch1"}, log_ch[1], 1);
        chk({nm, "_ch2"}, log_ch[2], 3);
        for (int i = 0; i < 3; i++) chk({nm, "_rf"}, log_rf[i], rf);
    endtask

    bit stable;
    int k6;

    initial begin
        rst_n = 0; in_s = 4'b0001; ch_en = 4'hF; ovf_clr = 0; evt_ready = 1;
        #25;
        chk("rst_valid", evt_valid, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_ch", evt_ch, 0);
        chk("rst_rf", {evt_rise, evt_fall}, 0);
        @(posedge clk); #1; rst_n = 1;

        // High input at release produces nothing
        cycles(20);
        chk("t1_events", log_ch.size(), 0);
        chk("t1_ovf", ovf, 0);
        ch_en[0] = 0; in_s[0] = 0;
        cycles(6);
        ch_en[0] = 1;
        cycles(2);
        chk("flush_events", log_ch.size(), 0);

        // Simultaneous rises: round-robin from reset pointer
        clr_log(); in_s = 4'b1011;
        wait_log("t3a_cnt", 3, 20);
        chk3("t3a", 2'b10);
        chk("t3a_b2b1", log_t[1] - log_t[0], 1);
        chk("t3a_b2b2", log_t[2] - log_t[1], 1);
        clr_log(); in_s = 4'b0000;
        wait_log("t3b_cnt", 3, 20);
        chk3("t3b", 2'b01);
        clr_log(); in_s = 4'b1011;
        wait_log("t3c_cnt", 3, 20);
        chk3("t3c", 2'b10);

        // Single rise latency
        clr_log(); in_s[2] = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_early", evt_valid, 0);
        end
        @(negedge clk);
        chk("t2_valid", evt_valid, 1);
        chk("t2_ch", evt_ch, 2);
        chk("t2_rf", {evt_rise, evt_fall}, 2'b10);
        @(negedge clk);
        chk("t2_one", evt_valid, 0);
        cycles(2);

        // Stall: ch3 holds output, ch1 fall+rise merge
        evt_ready = 0; in_s[3] = 0;
        cycles(6);
        chk("t4_hold_v", evt_valid, 1);
        chk("t4_hold_ch", evt_ch, 3);
        chk("t4_hold_rf", {evt_rise, evt_fall}, 2'b01);
        in_s[1] = 0; stable = 1;
        for (int k = 0; k < 20; k++) begin
            if (k == 10) in_s[1] = 1;
            @(negedge clk);
            if (!evt_valid || evt_ch != 2'd3 || {evt_rise, evt_fall} != 2'b01) stable = 0;
            @(posedge clk); #1;
        end
        chk("t4_stable", stable, 1);
        clr_log(); evt_ready = 1;
        wait_log("t4_cnt", 2, 10);
        chk("t4_e0_ch", log_ch[0], 3);
        chk("t4_e0_rf", log_rf[0], 2'b01);
        chk("t4_e1_ch", log_ch[1], 1);
        chk("t4_e1_rf", log_rf[1], 2'b11);

        // Overflow and write-1-to-clear
        evt_ready = 0;
        for (int k = 0; k < 4; k++) begin
            in_s[3] = ~in_s[3];
            cycles(4);
        end
        cycles(6);
        chk("t5_ovf", ovf, 4'b1000);
        cycles(3);
        chk("t5_sticky", ovf, 4'b1000);
        ovf_clr = 4'b1000;
        cycles(1);
        ovf_clr = 0;
        chk("t5_clr", ovf, 0);
        clr_log(); evt_ready = 1;
        wait_log("t5_cnt", 2, 10);
        chk("t5_e0_ch", log_ch[0], 3);
        chk("t5_e0_rf", log_rf[0], 2'b10);
        chk("t5_e1_ch", log_ch[1], 3);
        chk("t5_e1_rf", log_rf[1], 2'b11);

        // Disabled channel, then async reset with event held
        clr_log(); ch_en[2] = 0; in_s[2] = 0;
        cycles(10);
        ch_en[2] = 1;
        cycles(4);
        chk("t6_disabled", log_ch.size(), 0);
        evt_ready = 0; in_s[2] = 1;
        k6 = 0;
        while (!evt_valid && k6 < 10) begin
            cycles(1);
            k6++;
        end
        chk("t6_valid_up", evt_valid, 1);
        #4 rst_n = 0;
        #1;
        chk("t6_async_v", evt_valid, 0);
        chk("t6_async_ovf", ovf, 0);
        @(posedge clk); #1;
        rst_n = 1; evt_ready = 1; clr_log();
        cycles(20);
        chk("t6_after_rst", log_ch.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
